range_window_detector: RTL and testbench
========================================

// Module: range_window_detector
// PURPOSE
//   Parametrised, clocked successor to the combinational switch-range LED decoder.
//   - Flags when an unsigned sw value lies in a runtime window [lo, hi].
//   - Debounces entry and exit over STABLE_CYCLES consecutive valid samples.
//   - Pulses on entry/exit and counts entries; drives the board LED.
// PARAMETERS
//   WIDTH          8    sample and bound width, bits
//   STABLE_CYCLES  4    consecutive qualifying valid samples to change led (>=1)
//   CNT_W          16   width of hit_count
//   HYST           4    window widening while inside; used only with HYST_EN
// PORTS
//   clk           in   1        system clock, rising edge
//   rst_n         in   1        asynchronous active-low reset
//   sample_valid  in   1        sw is a sample this cycle; no sample when low
//   sw            in   WIDTH    unsigned sample
//   lo            in   WIDTH    window low bound, inclusive
//   hi            in   WIDTH    window high bound, inclusive
//   hit_clr       in   1        synchronous clear of hit_count
//   led           out  1        debounced in-window flag, registered
//   enter_pulse   out  1        1-cycle pulse on the led 0->1 edge
//   exit_pulse    out  1        1-cycle pulse on the led 1->0 edge
//   bound_err     out  1        combinational; 1 when lo > hi
//   hit_count     out  CNT_W    number of entries, saturating
// BEHAVIOUR
//   - Reset: state=S_OUT, run counter=0, led=0, both pulses=0, hit_count=0.
//     Takes effect immediately, in any state, including mid-count.
//   - inwin = (sw >= lo) && (sw <= hi), unsigned compare. If lo > hi, inwin=0.
//   - Only cycles with sample_valid=1 are evaluated.
//     Invalid cycles hold the state and the run counter.
//   - FSM, updated on the clk edge of a valid sample:
//     S_OUT:   inwin -> S_ENTER, run=1; else stay.
//     S_ENTER: inwin -> run+1; on reaching STABLE_CYCLES -> S_IN.
//              !inwin -> S_OUT, run=0.
//     S_IN:    !inwin -> S_EXIT, run=1; else stay.
//     S_EXIT:  !inwin -> run+1; on reaching STABLE_CYCLES -> S_OUT.
//              inwin -> S_IN, run=0.
//   - STABLE_CYCLES=1: S_OUT->S_IN and S_IN->S_OUT are direct.
//     S_ENTER and S_EXIT are never visited.
//   - led=1 exactly in S_IN and S_EXIT. It is registered.
//     It rises on the edge of the STABLE_CYCLES-th consecutive valid in-window sample.
//   - enter_pulse / exit_pulse: high for the one cycle after the edge where led changes.
//   - Counter widths: run counter is $clog2(STABLE_CYCLES+1) bits and never exceeds STABLE_CYCLES.
//   - hit_count: +1 on every enter edge; saturates at 2^CNT_W-1 (no wrap).
//     hit_clr alone -> 0.
//     hit_clr on the same edge as an entry -> 1.
//   - bound_err does not reset the FSM. Since inwin=0 while lo > hi, the FSM drifts to
//     S_OUT through normal debounce. Bound changes take effect on the next sample.
// CONFIGURATION
//   HYST_EN defined:
//     - In S_IN and S_EXIT, inwin uses the widened window [lo-HYST, hi+HYST].
//     - lo-HYST saturates at 0; hi+HYST saturates at 2^WIDTH-1.
//     - Widen with WIDTH+1-bit arithmetic; no wrap.
//     - Entry (S_OUT, S_ENTER) always uses [lo, hi].
//     - bound_err still forces inwin=0.
//   HYST_EN undefined: every state uses [lo, hi]; the HYST parameter is unused.
// TESTING
//   Default parameters, lo=160, hi=185 unless noted.
//   1. Entry: rst_n released, sample_valid=1, sw=170 held.
//      -> led=1 after 4th edge; enter_pulse high 1 cycle; hit_count=1.
//   2. Abort: sw=170 for 3 valid cycles, then 190.
//      -> led stays 0; FSM back in S_OUT; hit_count unchanged.
//   3. Edges: 160 and 185 held 4 samples each -> led=1.
//      159 and 186 held 4 samples each -> led stays 0.
//   4. Gaps: sw=170 with sample_valid=1,0,1,0,1,0,1.
//      -> led rises after the 7th edge (4th valid sample).
//   5. Bounds/reset: with led=1, set lo=200, hi=100.
//      -> bound_err=1; led falls after 4 samples with exit_pulse.
//      Then rst_n low while in S_ENTER -> led, run counter, hit_count all 0 at once.
//   6. HYST_EN, HYST=4: led=1, sw=188 for 8 samples -> led stays 1.
//      Then sw=190 for 4 samples -> led=0.
//      Also: hit_count at 2^CNT_W-1 plus one more entry -> stays 2^CNT_W-1.

Source files
------------

// File: rtl/range_window_detector_if.sv
// Bundle between range_window_detector and its driver.
// Sample, window bounds and clear in; led, pulses, error and count out.
interface range_window_detector_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);
    logic             sample_valid;
    logic [WIDTH-1:0] sw;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;
    logic             hit_clr;
    logic             led;
    logic             enter_pulse;
    logic             exit_pulse;
    logic             bound_err;
    logic [CNT_W-1:0] hit_count;

    modport master (
        output sample_valid, sw, lo, hi, hit_clr,
        input  led, enter_pulse, exit_pulse, bound_err, hit_count
    );

    modport slave (
        input  sample_valid, sw, lo, hi, hit_clr,
        output led, enter_pulse, exit_pulse, bound_err, hit_count
    );
endinterface

// File: rtl/range_window_detector.sv
// Debounced runtime window detector with entry/exit pulses and entry count.
// Optional HYST_EN macro widens the window by HYST while the led is on.
module range_window_detector #(
    parameter int WIDTH         = 8,
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 16,
    parameter int HYST          = 4
) (
    input logic                    clk,
    input logic                    rst_n,
    range_window_detector_if.slave bus
);
    localparam int RW = $clog2(STABLE_CYCLES + 1);
    localparam logic [RW-1:0] LAST = RW'(STABLE_CYCLES - 1);
    localparam logic [RW-1:0] ONE = RW'(1);
    localparam logic [WIDTH:0] HYST_W = (WIDTH + 1)'(HYST);
    localparam logic [WIDTH:0] TOP = {1'b0, {WIDTH{1'b1}}};
    localparam logic [CNT_W-1:0] CMAX = '1;
`ifdef HYST_EN
    localparam bit HYST_ON = 1'b1;
`else
    localparam bit HYST_ON = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_OUT,
        S_ENTER,
        S_IN,
        S_EXIT
    } state_t;

    state_t           state, nxt_state;
    logic [RW-1:0]    run, nxt_run;
    logic             enter, leave;
    logic             widen, inwin;
    logic [WIDTH:0]   lo_x, hi_x, sw_x;
    logic [WIDTH:0]   lo_w, hi_w, lo_e, hi_e;
    logic             led_q, enter_q, exit_q;
    logic [CNT_W-1:0] cnt_q;

    assign bus.bound_err   = bus.lo > bus.hi;
    assign bus.led         = led_q;
    assign bus.enter_pulse = enter_q;
    assign bus.exit_pulse  = exit_q;
    assign bus.hit_count   = cnt_q;

    // Effective window: widened (saturating) while inside, exact otherwise.
    always_comb begin
        lo_x  = {1'b0, bus.lo};
        hi_x  = {1'b0, bus.hi};
        sw_x  = {1'b0, bus.sw};
        lo_w  = (lo_x >= HYST_W) ? lo_x - HYST_W : '0;
        hi_w  = ((TOP - hi_x) < HYST_W) ? TOP : hi_x + HYST_W;
        widen = HYST_ON && (state == S_IN || state == S_EXIT);
        lo_e  = widen ? lo_w : lo_x;
        hi_e  = widen ? hi_w : hi_x;
        inwin = !bus.bound_err && (sw_x >= lo_e) && (sw_x <= hi_e);
    end

    // Debounce next-state: only valid samples advance or reset the run.
    always_comb begin
        nxt_state = state;
        nxt_run   = run;
        enter     = 1'b0;
        leave     = 1'b0;
        if (bus.sample_valid) begin
            unique case (state)
                S_OUT: begin
                    if (inwin) begin
                        if (STABLE_CYCLES == 1) begin
                            nxt_state = S_IN;
                            enter     = 1'b1;
                        end else begin
                            nxt_state = S_ENTER;
                            nxt_run   = ONE;
                        end
                    end
                end
                S_ENTER: begin
                    if (!inwin) begin
                        nxt_state = S_OUT;
                        nxt_run   = '0;
                    end else if (run == LAST) begin
                        nxt_state = S_IN;
                        nxt_run   = '0;
                        enter     = 1'b1;
                    end else begin
                        nxt_run = run + ONE;
                    end
                end
                S_IN: begin
                    if (!inwin) begin
                        if (STABLE_CYCLES == 1) begin
                            nxt_state = S_OUT;
                            leave     = 1'b1;
                        end else begin
                            nxt_state = S_EXIT;
                            nxt_run   = ONE;
                        end
                    end
                end
                S_EXIT: begin
                    if (inwin) begin
                        nxt_state = S_IN;
                        nxt_run   = '0;
                    end else if (run == LAST) begin
                        nxt_state = S_OUT;
                        nxt_run   = '0;
                        leave     = 1'b1;
                    end else begin
                        nxt_run = run + ONE;
                    end
                end
            endcase
        end
    end

    // State, registered led/pulses and saturating entry counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_OUT;
            run     <= '0;
            led_q   <= 1'b0;
            enter_q <= 1'b0;
            exit_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state   <= nxt_state;
            run     <= nxt_run;
            led_q   <= (nxt_state == S_IN) || (nxt_state == S_EXIT);
            enter_q <= enter;
            exit_q  <= leave;
            if (bus.hit_clr)
                cnt_q <= CNT_W'(enter);
            else if (enter && cnt_q != CMAX)
                cnt_q <= cnt_q + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_range_window_detector.sv
// Randomized and directed bench for range_window_detector.
// Reference model: streak of consecutive disagreeing valid samples flips led.
module tb_range_window_detector;
    localparam int WIDTH  = 8;
    localparam int STABLE = 4;
    localparam int CNT_W  = 5;
    localparam int HYST   = 4;
    localparam int CMAX   = (1 << CNT_W) - 1;
    localparam int SMAX   = (1 << WIDTH) - 1;
`ifdef HYST_EN
    localparam bit HYST_ON = 1'b1;
`else
    localparam bit HYST_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    range_window_detector_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    range_window_detector #(
        .WIDTH(WIDTH),
        .STABLE_CYCLES(STABLE),
        .CNT_W(CNT_W),
        .HYST(HYST)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int n_checks = 0;
    int n_fail = 0;
    int m_led, m_streak, m_cnt, m_enter, m_exit;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_in(int s, int l, int h, int led);
        int le, he;
        if (l > h) return 1'b0;
        le = l;
        he = h;
        if (HYST_ON && led != 0) begin
            le = (l - HYST < 0) ? 0 : l - HYST;
            he = (h + HYST > SMAX) ? SMAX : h + HYST;
        end
        return (s >= le) && (s <= he);
    endfunction

    task automatic model_reset();
        m_led = 0; m_streak = 0; m_cnt = 0; m_enter = 0; m_exit = 0;
    endtask

    task automatic check_outs(input string tag);
        check({tag, ".led"}, 32'(bus.led), 32'(m_led));
        check({tag, ".enter"}, 32'(bus.enter_pulse), 32'(m_enter));
        check({tag, ".exit"}, 32'(bus.exit_pulse), 32'(m_exit));
        check({tag, ".hits"}, 32'(bus.hit_count), 32'(m_cnt));
        check({tag, ".berr"}, 32'(bus.bound_err), 32'(int'(bus.lo) > int'(bus.hi)));
    endtask

    task automatic step(input string tag, input bit v, input int s, input bit clr);
        bit q;
        bus.sample_valid = v;
        bus.sw = s[WIDTH-1:0];
        bus.hit_clr = clr;
        @(posedge clk);
        m_enter = 0;
        m_exit = 0;
        if (v) begin
            q = model_in(s, int'(bus.lo), int'(bus.hi), m_led);
            if (int'(q) != m_led) m_streak++;
            else m_streak = 0;
            if (m_streak == STABLE) begin
                m_streak = 0;
                if (m_led == 0) begin m_led = 1; m_enter = 1; end
                else begin m_led = 0; m_exit = 1; end
            end
        end
        if (clr) m_cnt = m_enter;
        else if (m_enter != 0 && m_cnt < CMAX) m_cnt++;
        #1;
        check_outs(tag);
    endtask

    task automatic hold(input string tag, input int s, input int n);
        for (int i = 0; i < n; i++) step(tag, 1'b1, s, 1'b0);
    endtask

    initial begin
        int s, n, l, h;
        model_reset();
        bus.sample_valid = 1'b0;
        bus.sw = '0;
        bus.lo = 8'd160;
        bus.hi = 8'd185;
        bus.hit_clr = 1'b0;
        #12;
        check_outs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        hold("entry", 170, 5);
        hold("leave", 100, 4);
        hold("abort_in", 170, 3);
        hold("abort_out", 190, 2);
        hold("edge_lo", 160, 4);
        hold("out1", 50, 4);
        hold("edge_hi", 185, 4);
        hold("out2", 250, 4);
        hold("below", 159, 4);
        hold("above", 186, 4);
        for (int i = 0; i < 7; i++) step("gaps", (i % 2) == 0, 170, 1'b0);
        step("gaps_idle", 1'b0, 170, 1'b0);

        bus.lo = 8'd200;
        bus.hi = 8'd100;
        hold("berr", 170, 5);
        bus.lo = 8'd160;
        bus.hi = 8'd185;

        hold("hyst_in", 170, 4);
        hold("hyst_188", 188, 8);
        hold("hyst_190", 190, 4);
        hold("re_in", 170, 4);
        hold("re_out", 20, 4);
        hold("pre_rst", 170, 3);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outs("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        hold("post_rst", 170, 1);
        hold("post_rst_out", 20, 1);

        hold("clr_pre", 170, 3);
        step("clr_entry", 1'b1, 170, 1'b1);
        hold("clr_pre2", 20, 4);
        step("clr_alone", 1'b0, 20, 1'b1);

        for (int k = 0; k < CMAX + 3; k++) begin
            hold("sat_in", 172, STABLE);
            hold("sat_out", 10, STABLE);
        end

        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 15) == 0) begin
                l = $urandom_range(40, 200);
                h = ($urandom_range(0, 4) == 0) ? l - $urandom_range(1, 30)
                                                : l + $urandom_range(0, 40);
                if (h > SMAX) h = SMAX;
                bus.lo = l[WIDTH-1:0];
                bus.hi = h[WIDTH-1:0];
            end
            l = int'(bus.lo);
            h = int'(bus.hi);
            s = (l < h ? l : h) - 8 + int'($urandom_range(0, 16 + (l > h ? l - h : h - l)));
            if (s < 0) s = 0;
            if (s > SMAX) s = SMAX;
            n = $urandom_range(1, 6);
            for (int j = 0; j < n; j++)
                step("rand", $urandom_range(0, 4) != 0, s, $urandom_range(0, 40) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
